// File: rtl/game_pkg.sv
// Shared game definitions: state codes and the seven-segment glyph alphabet.
package game_pkg;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INTRO     = 3'd1;
    localparam logic [2:0] S_PVP       = 3'd2;
    localparam logic [2:0] S_PVAI      = 3'd3;
    localparam logic [2:0] S_GAME_OVER = 3'd4;

    typedef enum logic [4:0] {
        G_0, G_1, G_2, G_3, G_4, G_5, G_6, G_7, G_8, G_9,
        G_A, G_B, G_C, G_D, G_E, G_G, G_I, G_L, G_N, G_O,
        G_P, G_R, G_S, G_T, G_U, G_DASH, G_BLANK
    } glyph_t;

    localparam glyph_t GLYPH_BLANK = G_BLANK;

endpackage

// File: rtl/seg_glyph.sv
// Combinational glyph decoder: glyph code to active-low segments (bit 0 = a ... bit 6 = g).
module seg_glyph
    import game_pkg::*;
(
    input  logic [4:0] glyph,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (glyph)
            G_0:     seg = 7'h40;
            G_1:     seg = 7'h79;
            G_2:     seg = 7'h24;
            G_3:     seg = 7'h30;
            G_4:     seg = 7'h19;
            G_5:     seg = 7'h12;
            G_6:     seg = 7'h02;
            G_7:     seg = 7'h78;
            G_8:     seg = 7'h00;
            G_9:     seg = 7'h10;
            G_A:     seg = 7'h08;
            G_B:     seg = 7'h03;
            G_C:     seg = 7'h46;
            G_D:     seg = 7'h21;
            G_E:     seg = 7'h06;
            G_G:     seg = 7'h42;
            G_I:     seg = 7'h4F;
            G_L:     seg = 7'h47;
            G_N:     seg = 7'h2B;
            G_O:     seg = 7'h23;
            G_P:     seg = 7'h0C;
            G_R:     seg = 7'h2F;
            G_S:     seg = 7'h12;
            G_T:     seg = 7'h07;
            G_U:     seg = 7'h41;
            G_DASH:  seg = 7'h3F;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/state_banner.sv
// state_banner: per-state scrolling/static message on HEX5..HEX0.
// Define BANNER_BLINK_EN to blink the GAME_OVER message.
module state_banner
    import game_pkg::*;
#(
    parameter int TICK_DIV    = 12_500_000,
    parameter int BLINK_TICKS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] game_state,
    input  logic       pause,
    output logic [6:0] HEX5,
    output logic [6:0] HEX4,
    output logic [6:0] HEX3,
    output logic [6:0] HEX2,
    output logic [6:0] HEX1,
    output logic [6:0] HEX0,
    output logic       wrap
);

    localparam int         TW      = $clog2(TICK_DIV);
    localparam logic [2:0] ROM_ERR = 3'd5;

    if (TICK_DIV < 2 || BLINK_TICKS < 1) begin : g_param_check
        $error("state_banner: TICK_DIV must be >= 2 and BLINK_TICKS >= 1");
    end

    logic [2:0]    state_q;
    logic [3:0]    offset;
    logic [TW-1:0] tick_cnt;
    logic          wrap_pend;
    logic          tick;
    logic          change;
    logic          scrolling;
    logic          blank_disp;
    glyph_t        win [6];
    logic [6:0]    seg [6];

    function automatic glyph_t msg_glyph(input logic [2:0] st, input logic [3:0] idx);
        logic [2:0] sel;
        sel = (st > S_GAME_OVER) ? ROM_ERR : st;
        msg_glyph = G_BLANK;
        case ({sel, idx})
            {S_IDLE, 4'd0}:       msg_glyph = G_P;
            {S_IDLE, 4'd1}:       msg_glyph = G_R;
            {S_IDLE, 4'd2}:       msg_glyph = G_E;
            {S_IDLE, 4'd3}:       msg_glyph = G_S;
            {S_IDLE, 4'd4}:       msg_glyph = G_S;
            {S_IDLE, 4'd6}:       msg_glyph = G_S;
            {S_IDLE, 4'd7}:       msg_glyph = G_T;
            {S_IDLE, 4'd8}:       msg_glyph = G_A;
            {S_IDLE, 4'd9}:       msg_glyph = G_R;
            {S_IDLE, 4'd10}:      msg_glyph = G_T;
            {S_INTRO, 4'd0}:      msg_glyph = G_D;
            {S_INTRO, 4'd1}:      msg_glyph = G_E;
            {S_INTRO, 4'd2}:      msg_glyph = G_N;
            {S_INTRO, 4'd3}:      msg_glyph = G_N;
            {S_INTRO, 4'd4}:      msg_glyph = G_O;
            {S_INTRO, 4'd5}:      msg_glyph = G_N;
            {S_INTRO, 4'd6}:      msg_glyph = G_A;
            {S_INTRO, 4'd7}:      msg_glyph = G_N;
            {S_PVP, 4'd0}:        msg_glyph = G_P;
            {S_PVP, 4'd1}:        msg_glyph = G_1;
            {S_PVP, 4'd2}:        msg_glyph = G_DASH;
            {S_PVP, 4'd3}:        msg_glyph = G_DASH;
            {S_PVP, 4'd4}:        msg_glyph = G_P;
            {S_PVP, 4'd5}:        msg_glyph = G_2;
            {S_PVAI, 4'd0}:       msg_glyph = G_P;
            {S_PVAI, 4'd1}:       msg_glyph = G_1;
            {S_PVAI, 4'd2}:       msg_glyph = G_DASH;
            {S_PVAI, 4'd3}:       msg_glyph = G_DASH;
            {S_PVAI, 4'd4}:       msg_glyph = G_A;
            {S_PVAI, 4'd5}:       msg_glyph = G_I;
            {S_GAME_OVER, 4'd0}:  msg_glyph = G_G;
            {S_GAME_OVER, 4'd1}:  msg_glyph = G_A;
            {S_GAME_OVER, 4'd2}:  msg_glyph = G_N;
            {S_GAME_OVER, 4'd3}:  msg_glyph = G_N;
            {S_GAME_OVER, 4'd4}:  msg_glyph = G_E;
            {ROM_ERR, 4'd0}:      msg_glyph = G_E;
            {ROM_ERR, 4'd1}:      msg_glyph = G_R;
            {ROM_ERR, 4'd2}:      msg_glyph = G_R;
            default:              msg_glyph = G_BLANK;
        endcase
    endfunction

    assign tick      = (tick_cnt == TW'(TICK_DIV - 1)) && !pause;
    assign change    = (game_state != state_q);
    assign scrolling = (state_q == S_IDLE) || (state_q == S_INTRO);

    // A state change restarts the message and wins over a coincident tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            offset    <= 4'd0;
            tick_cnt  <= '0;
            wrap_pend <= 1'b0;
        end else begin
            wrap_pend <= 1'b0;
            if (change) begin
                state_q  <= game_state;
                offset   <= 4'd0;
                tick_cnt <= '0;
            end else if (!pause) begin
                if (tick) begin
                    tick_cnt <= '0;
                    if (scrolling) begin
                        offset    <= offset + 4'd1;
                        wrap_pend <= (offset == 4'd15);
                    end
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
            end
        end
    end

`ifdef BANNER_BLINK_EN
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [BW-1:0] blink_cnt;
    logic          blink_on;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (change) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (tick && state_q == S_GAME_OVER) begin
            if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
                blink_cnt <= '0;
                blink_on  <= !blink_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign blank_disp = !blink_on;
`else
    assign blank_disp = 1'b0;
`endif

    always_comb begin
        for (int d = 0; d < 6; d++) begin
            win[d] = blank_disp ? GLYPH_BLANK : msg_glyph(state_q, offset + 4'(d));
        end
    end

    for (genvar d = 0; d < 6; d++) begin : g_digit
        seg_glyph u_seg (
            .glyph (win[d]),
            .seg   (seg[d])
        );
    end

    // Output register: the window lags state_q/offset by one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            HEX5 <= 7'h7F;
            HEX4 <= 7'h7F;
            HEX3 <= 7'h7F;
            HEX2 <= 7'h7F;
            HEX1 <= 7'h7F;
            HEX0 <= 7'h7F;
            wrap <= 1'b0;
        end else begin
            HEX5 <= seg[0];
            HEX4 <= seg[1];
            HEX3 <= seg[2];
            HEX2 <= seg[3];
            HEX1 <= seg[4];
            HEX0 <= seg[5];
            wrap <= wrap_pend;
        end
    end

endmodule

// File: tb/tb_state_banner.sv
// Bench for state_banner: directed and randomized steps checked every cycle
// against a tick-count based message model.
module tb_state_banner;

    localparam int TD = 4;
    localparam int BT = 2;
`ifdef BANNER_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] game_state;
    logic       pause;
    logic [6:0] HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;
    logic       wrap;

    state_banner #(.TICK_DIV(TD), .BLINK_TICKS(BT)) dut (
        .clk        (clk),
        .reset      (reset),
        .game_state (game_state),
        .pause      (pause),
        .HEX5       (HEX5),
        .HEX4       (HEX4),
        .HEX3       (HEX3),
        .HEX2       (HEX2),
        .HEX1       (HEX1),
        .HEX0       (HEX0),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // model: state, ticks since entering it, clocks into current tick period
    int         m_state;
    int         m_ticks;
    int         m_phase;
    bit         m_wpend;
    logic [6:0] exp_hex [6];
    logic       exp_wrap;
    int         wraps;

    function automatic logic [6:0] seg_of(input byte c);
        case (c)
            "P": return 7'h0C;
            "r": return 7'h2F;
            "E": return 7'h06;
            "S": return 7'h12;
            "t": return 7'h07;
            "A": return 7'h08;
            "d": return 7'h21;
            "n": return 7'h2B;
            "o": return 7'h23;
            "1": return 7'h79;
            "2": return 7'h24;
            "-": return 7'h3F;
            "I": return 7'h4F;
            "G": return 7'h42;
            " ": return 7'h7F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic string msg_of(input int st);
        case (st)
            0: return "PrESS StArt     ";
            1: return "dEnnonAn        ";
            2: return "P1--P2          ";
            3: return "P1--AI          ";
            4: return "GAnnE           ";
            default: return "Err             ";
        endcase
    endfunction

    task automatic check7(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_ticks = 0;
        m_phase = 0;
        m_wpend = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check7({tag, "_HEX5"}, HEX5, exp_hex[0]);
        check7({tag, "_HEX4"}, HEX4, exp_hex[1]);
        check7({tag, "_HEX3"}, HEX3, exp_hex[2]);
        check7({tag, "_HEX2"}, HEX2, exp_hex[3]);
        check7({tag, "_HEX1"}, HEX1, exp_hex[4]);
        check7({tag, "_HEX0"}, HEX0, exp_hex[5]);
        check1({tag, "_wrap"}, wrap, exp_wrap);
    endtask

    task automatic cycle();
        string s;
        int    off;
        bit    blank;
        @(posedge clk);
        if (!reset) begin
            for (int d = 0; d < 6; d++) exp_hex[d] = 7'h7F;
            exp_wrap = 1'b0;
            model_reset();
        end else begin
            s     = msg_of(m_state);
            off   = (m_state <= 1) ? (m_ticks % 16) : 0;
            blank = BLINK && (m_state == 4) && (((m_ticks / BT) % 2) == 1);
            for (int d = 0; d < 6; d++)
                exp_hex[d] = blank ? 7'h7F : seg_of(s[(off + d) % 16]);
            exp_wrap = m_wpend;
            m_wpend  = 1'b0;
            if (int'(game_state) != m_state) begin
                m_state = int'(game_state);
                m_ticks = 0;
                m_phase = 0;
            end else if (!pause) begin
                if (m_phase == TD - 1) begin
                    m_phase = 0;
                    m_ticks++;
                    m_wpend = (m_state <= 1) && ((m_ticks % 16) == 0);
                end else begin
                    m_phase++;
                end
            end
        end
        #1;
        check_all("model");
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        reset      = 1'b0;
        game_state = 3'd0;
        pause      = 1'b0;
        model_reset();

        // reset held low for 3 cycles
        run(3);
        check7("rst_HEX5", HEX5, 7'h7F);
        check1("rst_wrap", wrap, 1'b0);

        reset = 1'b1;
        cycle();
        check7("idle_HEX5", HEX5, 7'h0C);
        check7("idle_HEX4", HEX4, 7'h2F);
        check7("idle_HEX3", HEX3, 7'h06);

        wraps = 0;
        for (int i = 0; i < 69; i++) begin
            cycle();
            if (wrap === 1'b1) wraps++;
        end
        checks++;
        assert (wraps == 1) else begin
            failures++;
            $error("FAIL wrap_count got=%0d expected=1", wraps);
        end

        run($urandom_range(3, 13));
        game_state = 3'd2;
        run(2);
        check7("pvp_HEX5", HEX5, 7'h0C);
        check7("pvp_HEX4", HEX4, 7'h79);
        check7("pvp_HEX3", HEX3, 7'h3F);
        check7("pvp_HEX0", HEX0, 7'h24);
        run(40);

        game_state = 3'd1;
        run($urandom_range(10, 30));
        pause = 1'b1;
        run(20);
        pause = 1'b0;
        run(70);

        game_state = 3'd4;
        run(2);
        check7("go_HEX5", HEX5, 7'h42);
        run(8);
        check7("go_blink_HEX5", HEX5, BLINK ? 7'h7F : 7'h42);
        run(30);

        game_state = 3'd6;
        run(2);
        check7("err_HEX5", HEX5, 7'h06);
        check7("err_HEX4", HEX4, 7'h2F);
        check7("err_HEX3", HEX3, 7'h2F);
        check7("err_HEX2", HEX2, 7'h7F);
        run(10);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 24) == 0) game_state = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) pause = ~pause;
            cycle();
        end
        pause = 1'b0;

        game_state = 3'd1;
        run($urandom_range(15, 40));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check7("async_HEX5", HEX5, 7'h7F);
        check7("async_HEX0", HEX0, 7'h7F);
        check1("async_wrap", wrap, 1'b0);
        run(2);
        reset      = 1'b1;
        game_state = 3'd0;
        run(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
